// File: rtl/shift_right_seq.sv
// Iterative right shifter: one bit per clock under a start/busy/done handshake.
// Serves SRL/SRA for the ALU and the byte-to-word offset conversion (shamt=2).
module shift_right_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in,
  input  logic [SHW-1:0]   shamt,
  input  logic             arith,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done
);

  localparam logic [SHW-1:0] CNT_ZERO = SHW'(0);
  localparam logic [SHW-1:0] CNT_ONE  = SHW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_q,   out_d;
  logic [SHW-1:0]   count_q, count_d;
  logic             mode_q,  mode_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;

  // Next-state, datapath and output decode; busy/done are derived from the
  // next state so they are registered alongside it.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    count_d = count_q;
    mode_d  = mode_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          out_d   = in;
          count_d = shamt;
          mode_d  = arith;
          // A zero shift skips SHIFT so the counter never wraps below zero.
          state_d = (shamt == CNT_ZERO) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        out_d   = {mode_q & out_q[WIDTH-1], out_q[WIDTH-1:1]};
        count_d = count_q - CNT_ONE;
        if (count_q == CNT_ONE) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State and output registers with immediate asynchronous abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      out_q   <= '0;
      count_q <= '0;
      mode_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      count_q <= count_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out  = out_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
